// File: rtl/apb_master_if.sv
// Command/response and APB bus bundle between a requester, apb_master and an APB responder.
// master modport is the apb_master view; slave modport is the view from the requester/responder side.
interface apb_master_if #(
  parameter int DATA = 32,
  parameter int ADDR = 32
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [ADDR-1:0] cmd_addr;
  logic [DATA-1:0] cmd_wdata;
  logic            rsp_valid;
  logic            rsp_write;
  logic [DATA-1:0] rsp_rdata;
  logic            rsp_err;
  logic [ADDR-1:0] paddr;
  logic            pwrite;
  logic [DATA-1:0] pwdata;
  logic            psel;
  logic            penable;
  logic [DATA-1:0] prdata;
  logic            pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           paddr, pwrite, pwdata, psel, penable
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           paddr, pwrite, pwdata, psel, penable
  );
endinterface

// File: rtl/apb_master.sv
// APB requester: one command -> SETUP/ACCESS transfer -> one-cycle response pulse; 4 cycles min per transfer.
// cmd_ready only in IDLE, no response backpressure. Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT waits.
module apb_master #(
  parameter int DATA    = 32,
  parameter int ADDR    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         pclk,
  input  logic         presetn,
  apb_master_if.master bus
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("apb_master: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [ADDR-1:0] paddr_q, paddr_d;
  logic [DATA-1:0] pwdata_q, pwdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_write_q, rsp_write_d;
  logic [DATA-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_TIMEOUT_EN
  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);
  logic [CW-1:0] wait_q, wait_d;
  logic          rsp_err_q, rsp_err_d;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
      wait_q      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
      wait_q      <= wait_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
    wait_d      = wait_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d   = bus.cmd_addr;
          pwrite_d  = bus.cmd_write;
          pwdata_d  = bus.cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_d    = '0;
`endif
      end
      ACCESS: begin
        // pready on the same edge as the last allowed wait still completes normally
        if (bus.pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = pwrite_q;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
          state_d     = RESP;
`ifdef APB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (wait_q == LAST_WAIT) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = pwrite_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          wait_d      = wait_q + 1'b1;
`endif
        end
      end
      RESP: begin
        rsp_valid_d = 1'b0;
`ifdef APB_TIMEOUT_EN
        rsp_err_d   = 1'b0;
`endif
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: behavioural APB memory slave with programmable wait states, scoreboard of
// expected responses (direction, data, error, latency, psel/penable cycle counts) popped on rsp_valid.
module tb_apb_master;
  localparam int DW = 32;
  localparam int AW = 32;
`ifdef APB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  apb_master_if #(.DATA(DW), .ADDR(AW)) bus ();

  apb_master #(.DATA(DW), .ADDR(AW), .TIMEOUT(TO)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus.master)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   nrsp  = 0;
  int   n_issued = 0;
  int   proto_viol = 0;
  int   psel_n = 0;
  int   pen_n  = 0;
  logic psel_prev = 1'b0;
  logic [DW-1:0] ref_mem [0:255] = '{default: '0};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // APB memory slave: pready held low for wait_n ACCESS cycles
  logic [DW-1:0] mem [0:255] = '{default: '0};
  int acc_cnt = 0;
  int wait_n  = 0;
  assign bus.prdata = mem[bus.paddr[7:0]];
  assign bus.pready = (acc_cnt >= wait_n);

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
    else                                         acc_cnt <= 0;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite)
      mem[bus.paddr[7:0]] <= bus.pwdata;
  end

  always @(negedge pclk) begin
    if (!presetn) begin
      psel_n    = 0;
      pen_n     = 0;
      psel_prev = 1'b0;
    end else begin
      if (bus.penable && !bus.psel) proto_viol++;
      if (bus.psel && !psel_prev && bus.penable) proto_viol++;
      if (bus.psel) begin
        psel_n++;
        if (bus.penable) pen_n++;
        if (sb.size() > 0 && (bus.paddr !== sb[0].addr || bus.pwrite !== sb[0].wr ||
                              bus.pwdata !== sb[0].wdata)) proto_viol++;
      end
      psel_prev = bus.psel;
      if (bus.rsp_valid) begin
        nrsp++;
        if (sb.size() == 0) begin
          chk("spurious_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_write",   {63'd0, bus.rsp_write}, {63'd0, e.wr});
          chk("rsp_rdata",   64'(bus.rsp_rdata), 64'(e.rdata));
          chk("rsp_err",     {63'd0, bus.rsp_err}, {63'd0, e.err});
          chk("latency",     64'(cyc - e.acc), 64'(e.lat));
          chk("psel_cycles", 64'(psel_n), 64'(e.lat));
          chk("pen_cycles",  64'(pen_n), 64'(e.lat - 1));
        end
        psel_n = 0;
        pen_n  = 0;
      end
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int waits, input bit abort, output int acc);
    exp_t e;
    bit   ok;
    ok  = 1'b0;
    acc = -1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge pclk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      if (bus.cmd_ready) begin
        wait_n = waits;
        @(posedge pclk);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      chk("accept_timeout", {63'd0, bus.cmd_ready}, 64'd1);
    end else begin
      acc     = cyc;
      e.wr    = wr;
      e.addr  = a;
      e.wdata = d;
      e.err   = abort;
      e.rdata = (wr || abort) ? '0 : ref_mem[a[7:0]];
      e.lat   = abort ? (TO + 1) : (2 + waits);
      e.acc   = acc;
      if (wr && !abort) ref_mem[a[7:0]] = d;
      sb.push_back(e);
      n_issued++;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && sb.size() > 0; i++) @(negedge pclk);
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge pclk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [AW-1:0] seq_a [0:7] = '{32'h0A, 32'h0B, 32'h0C, 32'h0D, 32'h0E, 32'h0D, 32'h0E, 32'h0A};
  logic [DW-1:0] seq_d [0:7] = '{32'hFACE, 32'hBEEF, 32'hCAFE, 32'hF00D, 32'h1234, 0, 0, 0};

  initial begin
    int acc, prev;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;

    // reset values
    repeat (3) @(negedge pclk);
    chk("rst_psel",      {63'd0, bus.psel}, 64'd0);
    chk("rst_penable",   {63'd0, bus.penable}, 64'd0);
    chk("rst_pwrite",    {63'd0, bus.pwrite}, 64'd0);
    chk("rst_paddr",     64'(bus.paddr), 64'd0);
    chk("rst_pwdata",    64'(bus.pwdata), 64'd0);
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_rsp_write", {63'd0, bus.rsp_write}, 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_rsp_err",   {63'd0, bus.rsp_err}, 64'd0);
    chk("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
    presetn = 1'b1;
    repeat (5) @(negedge pclk);
    chk("idle_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
    chk("idle_psel",      {63'd0, bus.psel}, 64'd0);

    // zero-wait write
    issue(1'b1, 32'h0A, 32'hFACE, 0, 1'b0, acc);
    drain();
    chk("paddr_hold",  64'(bus.paddr), 64'h0A);
    chk("pwdata_hold", 64'(bus.pwdata), 64'hFACE);
    chk("pwrite_hold", {63'd0, bus.pwrite}, 64'd1);

    // back-to-back writes then reads
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      issue((i < 5), seq_a[i], seq_d[i], 0, 1'b0, acc);
      if (i > 0) chk("b2b_gap", 64'(acc - prev), 64'd4);
      prev = acc;
    end
    drain();
    repeat (3) @(negedge pclk);
    chk("rdata_hold", 64'(bus.rsp_rdata), 64'hFACE);

    // read with 3 wait states
    issue(1'b0, 32'h0C, 32'h0, 3, 1'b0, acc);
    drain();

    // reset in the middle of ACCESS
    issue(1'b0, 32'h0E, 32'h0, 50, 1'b0, acc);
    repeat (3) @(negedge pclk);
    #2 presetn = 1'b0;
    #1;
    chk("midrst_psel",      {63'd0, bus.psel}, 64'd0);
    chk("midrst_penable",   {63'd0, bus.penable}, 64'd0);
    chk("midrst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
    chk("midrst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    sb.delete();
    n_issued--;
    @(negedge pclk);
    #2 presetn = 1'b1;
    repeat (3) @(negedge pclk);
    issue(1'b0, 32'h0B, 32'h0, 0, 1'b0, acc);
    drain();

`ifdef APB_TIMEOUT_EN
    issue(1'b0, 32'h0D, 32'h0, 1000, 1'b1, acc);
    drain();
    issue(1'b0, 32'h0D, 32'h0, TO - 1, 1'b0, acc);
    drain();
    issue(1'b1, 32'h0E, 32'h5555, 0, 1'b0, acc);
    issue(1'b0, 32'h0E, 32'h0, 1, 1'b0, acc);
    drain();
`else
    issue(1'b0, 32'h0D, 32'h0, 20, 1'b0, acc);
    drain();
`endif

    repeat (4) @(negedge pclk);
    chk("protocol_violations", 64'(proto_viol), 64'd0);
    chk("rsp_count", 64'(nrsp), 64'(n_issued));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
